// File: rtl/multicycle_control_pkg.sv
// rtl/multicycle_control_pkg.sv - shared state, opcode and control-code definitions
// Used by multicycle_control, ctrl_output_decode and the Datapath.
// Contents: state_t FSM encoding, opcode constants, ALUOp codes,
// ALUSrcB / PCSource codes, ctrl_t bundle of all Datapath controls.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    S_START      = 4'd0,
    S_FETCH      = 4'd1,
    S_DECODE     = 4'd2,
    S_MEM_ADDR   = 4'd3,
    S_MEM_READ   = 4'd4,
    S_WB         = 4'd5,
    S_MEM_WRITE  = 4'd6,
    S_EXECUTE    = 4'd7,
    S_R_COMPLETE = 4'd8,
    S_BRANCH     = 4'd9,
    S_JUMP       = 4'd10,
`ifdef CTRL_IMM_ALU_EN
    S_HALT       = 4'd11,
    S_I_EXEC     = 4'd12,
    S_I_COMPLETE = 4'd13
`else
    S_HALT       = 4'd11
`endif
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_HALT  = 6'b111111;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_ONE    = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write_cond;
    logic       pc_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic       alu_src_a;
    logic       reg_write;
    logic       reg_dst;
    logic [1:0] pc_source;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
    logic       halted;
  } ctrl_t;

endpackage

// File: rtl/multicycle_control_ctrl_output_decode.sv
// rtl/multicycle_control_ctrl_output_decode.sv - state to Datapath control mapping
// Ports: state (current FSM state), mem_ready (memory handshake),
// funct_alu (IR funct[3:0]), opcode (only with CTRL_IMM_ALU_EN),
// ctrl (all Datapath controls plus halted).
module ctrl_output_decode
  import multicycle_control_pkg::*;
(
  input  state_t     state,
  input  logic       mem_ready,
`ifdef CTRL_IMM_ALU_EN
  input  logic [5:0] opcode,
`endif
  input  logic [3:0] funct_alu,
  output ctrl_t      ctrl
);

`ifdef CTRL_IMM_ALU_EN
  logic [3:0] imm_alu_op;

  always_comb begin
    case (opcode)
      OP_ANDI: imm_alu_op = ALU_AND;
      OP_ORI:  imm_alu_op = ALU_OR;
      default: imm_alu_op = ALU_ADD;
    endcase
  end
`endif

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_ONE;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_source = PCSRC_ALU;
        // PC and IR only update once the instruction word has arrived.
        ctrl.pc_write  = mem_ready;
        ctrl.ir_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEM_READ:  ctrl.mem_read = 1'b1;
      S_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: ctrl.mem_write = 1'b1;
      S_EXECUTE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = funct_alu;
      end
      S_R_COMPLETE: begin
        // IR is stable outside FETCH, so funct still holds the ALU op.
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = funct_alu;
      end
      S_BRANCH: begin
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_REG;
        ctrl.alu_op        = ALU_SUB;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      S_HALT: ctrl.halted = 1'b1;
`ifdef CTRL_IMM_ALU_EN
      S_I_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = imm_alu_op;
      end
      S_I_COMPLETE: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = imm_alu_op;
      end
`endif
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle CPU control FSM driving the Datapath
// Optional feature macro: CTRL_IMM_ALU_EN (ADDI/ANDI/ORI support).
// Ports: clk, reset (async active-low), opcode/funct (IR fields), zero,
// mem_ready (memory handshake), Datapath controls PCWriteCond..RegDst,
// PCSource, ALUSrcB, ALUOp, illegal (DECODE pulse), halted.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter int FUNCT_W  = 6,
  parameter int ALUOP_W  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [FUNCT_W-1:0]  funct,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                PCWriteCond,
  output logic                PCWrite,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                MemtoReg,
  output logic                IRWrite,
  output logic                ALUSrcA,
  output logic                RegWrite,
  output logic                RegDst,
  output logic [1:0]          PCSource,
  output logic [1:0]          ALUSrcB,
  output logic [ALUOP_W-1:0]  ALUOp,
  output logic                illegal,
  output logic                halted
);

  state_t state;
  state_t state_next;
  ctrl_t  ctrl;

  // Branch gating lives in the Datapath; only funct[3:0] selects the ALU op.
  logic unused_bits;
  assign unused_bits = ^{funct[FUNCT_W-1:4], zero};

  always_comb begin
    state_next = S_FETCH;
    illegal    = 1'b0;
    case (state)
      S_START:     state_next = S_FETCH;
      S_FETCH:     state_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:      state_next = S_EXECUTE;
          OP_LW, OP_SW:  state_next = S_MEM_ADDR;
          OP_BEQ:        state_next = S_BRANCH;
          OP_J:          state_next = S_JUMP;
          OP_HALT:       state_next = S_HALT;
`ifdef CTRL_IMM_ALU_EN
          OP_ADDI, OP_ANDI, OP_ORI: state_next = S_I_EXEC;
`endif
          default: begin
            state_next = S_FETCH;
            illegal    = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR:   state_next = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:   state_next = mem_ready ? S_WB : S_MEM_READ;
      S_WB:         state_next = S_FETCH;
      S_MEM_WRITE:  state_next = mem_ready ? S_FETCH : S_MEM_WRITE;
      S_EXECUTE:    state_next = S_R_COMPLETE;
      S_R_COMPLETE: state_next = S_FETCH;
      S_BRANCH:     state_next = S_FETCH;
      S_JUMP:       state_next = S_FETCH;
      S_HALT:       state_next = S_HALT;
`ifdef CTRL_IMM_ALU_EN
      S_I_EXEC:     state_next = S_I_COMPLETE;
      S_I_COMPLETE: state_next = S_FETCH;
`endif
      default:      state_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_START;
    else        state <= state_next;
  end

  ctrl_output_decode u_decode (
    .state     (state),
    .mem_ready (mem_ready),
`ifdef CTRL_IMM_ALU_EN
    .opcode    (opcode[5:0]),
`endif
    .funct_alu (funct[3:0]),
    .ctrl      (ctrl)
  );

  assign PCWriteCond = ctrl.pc_write_cond;
  assign PCWrite     = ctrl.pc_write;
  assign MemRead     = ctrl.mem_read;
  assign MemWrite    = ctrl.mem_write;
  assign MemtoReg    = ctrl.mem_to_reg;
  assign IRWrite     = ctrl.ir_write;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign RegWrite    = ctrl.reg_write;
  assign RegDst      = ctrl.reg_dst;
  assign PCSource    = ctrl.pc_source;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign ALUOp       = ALUOP_W'(ctrl.alu_op);
  assign halted      = ctrl.halted;

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Moore-style control FSM for the multicycle CPU. It sits directly upstream of `Datapath` and drives every one of its control inputs. It sequences fetch, decode, execute, memory and write-back from the opcode and funct fields of the instruction register. It also stalls on a memory-ready handshake and flags illegal and halt opcodes.

## Interface
Parameters:
- `OPCODE_W`, 6, opcode field width
- `FUNCT_W`, 6, funct field width
- `ALUOP_W`, 4, ALUOp width

Ports:
- `clk`  input  1  system clock, rising edge
- `reset`  input  1  asynchronous, active-low reset
- `opcode`  input  OPCODE_W  IR[31:26] from Datapath
- `funct`  input  FUNCT_W  IR[5:0] from Datapath
- `zero`  input  1  ALU zero flag (informational; gating happens in Datapath via PCWriteCond)
- `mem_ready`  input  1  memory completes the current read or write this cycle
- `PCWriteCond, PCWrite, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst`  output  1 each  to Datapath
- `PCSource`  output  2  00 ALU result, 01 ALUOut, 10 jump target
- `ALUSrcB`  output  2  00 reg B, 01 constant 1, 10 sign-extended imm, 11 sign-extended imm shifted
- `ALUOp`  output  ALUOP_W  ALU operation: 0010 ADD, 0110 SUB, 0000 AND, 0001 OR
- `illegal`  output  1  one-cycle pulse on an unknown opcode
- `halted`  output  1  high while in HALT

## Operation
States: START, FETCH, DECODE, MEM_ADDR, MEM_READ, WB, MEM_WRITE, EXECUTE, R_COMPLETE, BRANCH, JUMP, HALT (plus I_EXEC and I_COMPLETE under the macro).
- START: all outputs 0; unconditionally goes to FETCH next cycle.
- FETCH: MemRead=1, ALUSrcA=0, ALUSrcB=01, ALUOp=ADD, PCSource=00.
  - PCWrite and IRWrite are asserted only when mem_ready=1; that is the only Mealy qualification in the block.
  - mem_ready=1 → DECODE; otherwise stay in FETCH.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=ADD (precomputes the branch target). Next state by opcode:
  - 000000 → EXECUTE
  - 100011 or 101011 → MEM_ADDR
  - 000100 → BRANCH
  - 000010 → JUMP
  - 111111 → HALT
  - anything else → FETCH with illegal=1 for this cycle
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=ADD. LW → MEM_READ; SW → MEM_WRITE.
- MEM_READ: MemRead=1. Holds until mem_ready=1, then → WB.
- WB: RegWrite=1, MemtoReg=1, RegDst=0. Then → FETCH.
- MEM_WRITE: MemWrite=1. Stays asserted until mem_ready=1, then → FETCH.
- EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=funct[3:0]. Then → R_COMPLETE.
- R_COMPLETE: RegWrite=1, RegDst=1, MemtoReg=0, ALUSrcA=1, ALUSrcB=00, ALUOp held. Then → FETCH.
- BRANCH: PCWriteCond=1, PCSource=01, ALUSrcA=1, ALUSrcB=00, ALUOp=SUB. Then → FETCH.
- JUMP: PCWrite=1, PCSource=10. Then → FETCH.
- HALT: halted=1, all other outputs 0. Absorbing; only reset leaves it.
- Every output not listed for a state is 0 in that state.

## Timing
- Reset asserted (asynchronously) → state=START, all outputs 0 immediately. Outputs decode from the state register only, plus the FETCH mem_ready qualification.
- First FETCH is the cycle after reset deasserts.
- Cycle counts with mem_ready tied high: LW 5, SW 4, R-type 4, BEQ 3, J 3, I-type 4. Each mem_ready=0 cycle in FETCH, MEM_READ or MEM_WRITE adds one cycle.
- mem_ready is ignored in every other state.
- Reset mid-instruction aborts it. No partial write is completed after reset.
- illegal is high only in the DECODE cycle; it is never high in consecutive cycles.
- Unreachable state encodings → FETCH on the next edge, with all outputs 0 while in them.

## Configuration
- `CTRL_IMM_ALU_EN` defined: opcodes 001000 (ADDI), 001100 (ANDI) and 001101 (ORI) go DECODE → I_EXEC → I_COMPLETE → FETCH.
  - I_EXEC: ALUSrcA=1, ALUSrcB=10, ALUOp = ADD, AND or OR respectively.
  - I_COMPLETE: RegWrite=1, RegDst=0, MemtoReg=0, with the I_EXEC ALU controls held.
- Not defined: those opcodes are illegal (pulse, → FETCH), and I_EXEC and I_COMPLETE do not exist.

## Structure
- Shared package holds: the state enum/localparams, opcode constants, ALUOp codes, and the ALUSrcB and PCSource codes. Datapath uses the same package.
- One natural sub-module, `ctrl_output_decode`: combinational mapping from state, mem_ready and funct to all outputs.
- The top level holds the state register and the next-state logic.

## Test plan
- Reset low for 5 cycles, then release → all outputs 0 during reset; START; FETCH on the next edge with MemRead=1, ALUSrcB=01, ALUOp=0010.
- LW (opcode 100011), mem_ready held 0 for 2 cycles in FETCH and 1 cycle in MEM_READ → IRWrite/PCWrite rise only in the ready cycle; RegWrite=1 with MemtoReg=1 in the WB cycle; 8 cycles total.
- R-type, funct=100110 → EXECUTE shows ALUOp=0110; the next cycle shows RegWrite=1, RegDst=1; back in FETCH after 4 cycles.
- BEQ then J → BRANCH asserts PCWriteCond=1, PCSource=01, ALUOp=0110; JUMP asserts PCWrite=1, PCSource=10.
- Opcode 010101 → illegal=1 for exactly 1 cycle, then FETCH. Opcode 111111 → halted=1 and stays there for 20 cycles regardless of mem_ready.
- Reset asserted mid-MEM_WRITE → MemWrite drops to 0 within the same cycle, without waiting for a clock edge. With `CTRL_IMM_ALU_EN` defined, ADDI (001000) → I_EXEC ALUSrcB=10, ALUOp=0010, then RegWrite=1, RegDst=0.
